ifu_fetch: RTL and testbench

Instruction fetch unit that sits between the `pc` block and instruction memory. It accepts fetch addresses over a valid/ready handshake and issues them to instruction memory over a request/grant port. It matches in-order read responses back to their addresses and buffers the resulting instructions for decode in an output FIFO. On a redirect (`flush_i`, driven by the same jump-enable that steers the PC), it discards all pending and in-flight fetches so that no stale instruction reaches decode.

---
 rtl/ifu_fetch_if.sv | 39 +++
 rtl/ifu_fetch.sv | 151 +++++++++++++++
 tb/tb_ifu_fetch.sv | 338 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/ifu_fetch_if.sv
// Signal bundle for the instruction fetch unit: PC-side address handshake,
// instruction-memory request/grant/response port and decode-side FIFO port.
//
// Handshake semantics (used on every valid/ready pair in this bundle):
//   a transfer happens on a rising clock edge where both valid and ready are 1
//   (pc_valid_i/pc_ready_o, imem_req_o/imem_gnt_i, inst_valid_o/inst_ready_i).
//   The ifu holds imem_req_o/imem_addr_o and inst_valid_o/inst_o/inst_addr_o
//   stable until they are taken, except on flush or reset. pc_ready_o never
//   depends on pc_valid_i. imem_rvalid_i is a one-cycle pulse per earlier grant,
//   returned in grant order, with no ready.
interface ifu_fetch_if;
  logic [31:0] pc_i;
  logic        pc_valid_i;
  logic        pc_ready_o;
  logic        flush_i;
  logic        imem_req_o;
  logic [31:0] imem_addr_o;
  logic        imem_gnt_i;
  logic        imem_rvalid_i;
  logic [31:0] imem_rdata_i;
  logic        inst_valid_o;
  logic [31:0] inst_o;
  logic [31:0] inst_addr_o;
  logic        inst_ready_i;

  // View of the fetch unit itself.
  modport slave (
    input  pc_i, pc_valid_i, flush_i, imem_gnt_i, imem_rvalid_i, imem_rdata_i,
           inst_ready_i,
    output pc_ready_o, imem_req_o, imem_addr_o, inst_valid_o, inst_o, inst_addr_o
  );

  // View of the surrounding system (pc block, memory, decode).
  modport master (
    output pc_i, pc_valid_i, flush_i, imem_gnt_i, imem_rvalid_i, imem_rdata_i,
           inst_ready_i,
    input  pc_ready_o, imem_req_o, imem_addr_o, inst_valid_o, inst_o, inst_addr_o
  );
endinterface

// File: rtl/ifu_fetch.sv
// Instruction fetch unit: takes fetch addresses from the pc block, issues them
// to instruction memory, tags in-order responses with their address and
// buffers them for decode. A flush discards every pending and in-flight fetch.
// Credits (used_q) cover the pending request, granted-not-returned reads and
// buffered instructions, so the output FIFO can never overflow.
module ifu_fetch #(
  parameter int DEPTH = 4
) (
  input logic       clk,
  input logic       rst,
  ifu_fetch_if.slave bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL_C = CW'(DEPTH);

  // Request register toward memory
  logic          req_q, req_d;
  logic [31:0]   addr_q, addr_d;

  // Address tags of granted reads, oldest first
  logic [31:0]   tag_mem [DEPTH];
  logic [AW-1:0] tag_wptr_q, tag_rptr_q;
  logic [CW-1:0] tag_cnt_q, tag_cnt_d;

  // Output FIFO toward decode
  logic [31:0]   dat_mem [DEPTH];
  logic [31:0]   iad_mem [DEPTH];
  logic [AW-1:0] fifo_wptr_q, fifo_rptr_q;
  logic [CW-1:0] fifo_cnt_q;

  // Credit and discard counters
  logic [CW-1:0] used_q, used_d;
  logic [CW-1:0] discard_q, discard_d;

  logic pc_ready, accept, grant, resp, drop, push, pop, fifo_valid;

  // Handshake qualifiers; a pop never frees a credit in its own cycle.
  always_comb begin
    pc_ready   = !bus.flush_i && !rst && (used_q < FULL_C) &&
                 (!req_q || bus.imem_gnt_i);
    accept     = bus.pc_valid_i && pc_ready;
    grant      = req_q && bus.imem_gnt_i;
    resp       = bus.imem_rvalid_i && (tag_cnt_q != '0);
    drop       = resp && (discard_q != '0);
    push       = resp && !drop && !bus.flush_i;
    fifo_valid = (fifo_cnt_q != '0);
    pop        = fifo_valid && bus.inst_ready_i;
  end

  // Next-state for request register and counters; flush rebases credits on
  // the reads still owed by memory (including a grant in the flush cycle).
  always_comb begin
    req_d     = req_q;
    addr_d    = addr_q;
    if (accept) begin
      req_d  = 1'b1;
      addr_d = {bus.pc_i[31:2], 2'b00};
    end else if (grant) begin
      req_d  = 1'b0;
    end
    if (bus.flush_i) begin
      req_d = 1'b0;
    end
    tag_cnt_d = tag_cnt_q + CW'(grant) - CW'(resp);
    if (bus.flush_i) begin
      discard_d = tag_cnt_d;
      used_d    = tag_cnt_d;
    end else begin
      discard_d = discard_q - CW'(drop);
      used_d    = used_q + CW'(accept) - CW'(pop) - CW'(drop);
    end
  end

  assign bus.pc_ready_o   = pc_ready;
  assign bus.imem_req_o   = req_q;
  assign bus.imem_addr_o  = addr_q;
  assign bus.inst_valid_o = fifo_valid;
  assign bus.inst_o       = fifo_valid ? dat_mem[fifo_rptr_q] : '0;
  assign bus.inst_addr_o  = fifo_valid ? iad_mem[fifo_rptr_q] : '0;

  // Request register: loads on accept, holds until granted or flushed.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      req_q  <= 1'b0;
      addr_q <= '0;
    end else begin
      req_q  <= req_d;
      addr_q <= addr_d;
    end
  end

  // Tag queue pointers: push on grant, pop on every accepted response.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tag_wptr_q <= '0;
      tag_rptr_q <= '0;
      tag_cnt_q  <= '0;
    end else begin
      if (grant) tag_wptr_q <= tag_wptr_q + 1'b1;
      if (resp)  tag_rptr_q <= tag_rptr_q + 1'b1;
      tag_cnt_q <= tag_cnt_d;
    end
  end

  // Tag storage: address of each granted read.
  always_ff @(posedge clk) begin
    if (grant) tag_mem[tag_wptr_q] <= addr_q;
  end

  // Output FIFO pointers; flush empties it in one cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fifo_wptr_q <= '0;
      fifo_rptr_q <= '0;
      fifo_cnt_q  <= '0;
    end else if (bus.flush_i) begin
      fifo_wptr_q <= '0;
      fifo_rptr_q <= '0;
      fifo_cnt_q  <= '0;
    end else begin
      if (push) fifo_wptr_q <= fifo_wptr_q + 1'b1;
      if (pop)  fifo_rptr_q <= fifo_rptr_q + 1'b1;
      fifo_cnt_q <= fifo_cnt_q + CW'(push) - CW'(pop);
    end
  end

  // Output FIFO storage: instruction word paired with its fetch address.
  always_ff @(posedge clk) begin
    if (push) begin
      dat_mem[fifo_wptr_q] <= bus.imem_rdata_i;
      iad_mem[fifo_wptr_q] <= tag_mem[tag_rptr_q];
    end
  end

  // Credit and discard counters.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      used_q    <= '0;
      discard_q <= '0;
    end else begin
      used_q    <= used_d;
      discard_q <= discard_d;
    end
  end

  // A response with no outstanding grant is a memory protocol violation.
  a_rvalid_has_tag: assert property (@(posedge clk) disable iff (rst)
    bus.imem_rvalid_i |-> (tag_cnt_q != '0));

endmodule

// File: tb/tb_ifu_fetch.sv
// Bench for ifu_fetch: directed scenarios plus a randomized phase, checked
// against a transaction-level model (pending request, in-order memory queue
// with live/stale marks, expected instruction queue).
module tb_ifu_fetch;
  localparam int DEPTH = 4;
  localparam logic [31:0] KEY = 32'hA5A5_0000;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  ifu_fetch_if bus ();

  ifu_fetch #(.DEPTH(DEPTH)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // ---------------- bookkeeping ----------------
  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  typedef struct {
    logic [31:0] addr;
    bit          live;
    int          due;
  } mem_t;

  mem_t        mem_q [$];   // granted reads owed by memory, grant order
  logic [31:0] exp_q [$];   // instructions decode should see next, in order
  bit          m_req  = 1'b0;
  logic [31:0] m_addr = '0;

  int  lat_min    = 1;
  int  lat_max    = 1;
  bit  gnt_manual = 1'b0;
  bit  gnt_val    = 1'b0;
  bit  gnt_rand   = 1'b0;

  int          pop_cyc_q [$];
  int          acc_cyc_q [$];
  logic [31:0] last_pop_addr = '0;
  int          pop_cnt   = 0;
  int          grant_cnt = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic chk_i(input string tag, input int obs, input int exp);
    checks++;
    assert (obs == exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // ---------------- memory responder ----------------
  always @(posedge clk) begin
    #1;
    cyc++;
    if (rst) begin
      bus.imem_rvalid_i = 1'b0;
      bus.imem_rdata_i  = '0;
    end else if (mem_q.size() != 0 && mem_q[0].due <= cyc) begin
      bus.imem_rvalid_i = 1'b1;
      bus.imem_rdata_i  = mem_q[0].addr ^ KEY;
    end else begin
      bus.imem_rvalid_i = 1'b0;
      bus.imem_rdata_i  = $urandom();
    end
    if (gnt_manual)    bus.imem_gnt_i = gnt_val;
    else if (gnt_rand) bus.imem_gnt_i = 1'($urandom_range(0, 1));
    else               bus.imem_gnt_i = 1'b1;
  end

  // ---------------- monitor / scoreboard ----------------
  always @(negedge clk) begin
    int   used_m;
    bit   exp_rdy;
    bit   gr;
    mem_t e;
    if (rst) begin
      chk1("rst_pc_ready",   bus.pc_ready_o,   1'b0);
      chk1("rst_imem_req",   bus.imem_req_o,   1'b0);
      chk ("rst_imem_addr",  bus.imem_addr_o,  32'h0);
      chk1("rst_inst_valid", bus.inst_valid_o, 1'b0);
      chk ("rst_inst",       bus.inst_o,       32'h0);
      chk ("rst_inst_addr",  bus.inst_addr_o,  32'h0);
      mem_q.delete();
      exp_q.delete();
      m_req  = 1'b0;
      m_addr = '0;
    end else begin
      used_m  = (m_req ? 1 : 0) + mem_q.size() + exp_q.size();
      exp_rdy = !bus.flush_i && (used_m < DEPTH) && (!m_req || bus.imem_gnt_i);
      chk1("pc_ready",   bus.pc_ready_o,   exp_rdy);
      chk1("imem_req",   bus.imem_req_o,   m_req);
      if (m_req) chk("imem_addr", bus.imem_addr_o, m_addr);
      chk1("inst_valid", bus.inst_valid_o, exp_q.size() != 0);
      if (exp_q.size() != 0) begin
        chk("inst_addr", bus.inst_addr_o, exp_q[0]);
        chk("inst_data", bus.inst_o,      exp_q[0] ^ KEY);
      end
      if (bus.imem_req_o && bus.imem_gnt_i) grant_cnt++;
      // decode pop
      if (exp_q.size() != 0 && bus.inst_ready_i) begin
        last_pop_addr = exp_q.pop_front();
        pop_cyc_q.push_back(cyc);
        pop_cnt++;
      end
      // memory response
      if (bus.imem_rvalid_i && mem_q.size() != 0) begin
        e = mem_q.pop_front();
        if (e.live && !bus.flush_i) exp_q.push_back(e.addr);
      end
      // grant
      gr = m_req && bus.imem_gnt_i;
      if (gr) mem_q.push_back('{addr: m_addr, live: 1'b1,
                                due: cyc + int'($urandom_range(lat_min, lat_max))});
      // address accept
      if (bus.pc_valid_i && exp_rdy) begin
        m_req  = 1'b1;
        m_addr = {bus.pc_i[31:2], 2'b00};
        acc_cyc_q.push_back(cyc);
      end else if (gr) begin
        m_req = 1'b0;
      end
      // redirect
      if (bus.flush_i) begin
        exp_q.delete();
        foreach (mem_q[i]) mem_q[i].live = 1'b0;
        m_req = 1'b0;
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  task automatic fetch(input logic [31:0] a);
    bit done = 1'b0;
    bus.pc_i       = a;
    bus.pc_valid_i = 1'b1;
    for (int k = 0; k < 200 && !done; k++) begin
      @(negedge clk);
      done = bus.pc_ready_o;
      @(posedge clk);
      #2;
    end
    bus.pc_valid_i = 1'b0;
    chk1("fetch_accepted", done, 1'b1);
  endtask

  // ---------------- directed + random stimulus ----------------
  initial begin
    int  pop0;
    int  gcnt0;
    bit  acc;

    rst              = 1'b1;
    bus.pc_i         = '0;
    bus.pc_valid_i   = 1'b0;
    bus.flush_i      = 1'b0;
    bus.inst_ready_i = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    rst = 1'b0;

    // Stream: four back-to-back fetches, zero-wait memory, decode ready
    bus.inst_ready_i = 1'b1;
    pop_cyc_q.delete();
    acc_cyc_q.delete();
    fetch(32'h0); fetch(32'h4); fetch(32'h8); fetch(32'hC);
    idle(8);
    chk_i("stream_pop_count", pop_cyc_q.size(), 4);
    chk_i("stream_accepts", acc_cyc_q.size(), 4);
    for (int i = 0; i < 4; i++) begin
      if (i < pop_cyc_q.size() && acc_cyc_q.size() != 0)
        chk_i("stream_pop_cycle", pop_cyc_q[i] - acc_cyc_q[0], 3 + i);
    end
    chk("stream_last_addr", last_pop_addr, 32'hC);

    // Wait states: grant held low for three cycles
    gnt_manual = 1'b1;
    gnt_val    = 1'b0;
    idle(1);
    fetch(32'h10);
    gcnt0 = grant_cnt;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk1("ws_req",      bus.imem_req_o,  1'b1);
      chk ("ws_addr",     bus.imem_addr_o, 32'h10);
      chk1("ws_pc_ready", bus.pc_ready_o,  1'b0);
      if (i == 2) gnt_val = 1'b1;
      @(posedge clk);
      #2;
    end
    gnt_val = 1'b0;
    idle(3);
    chk_i("ws_grants", grant_cnt - gcnt0, 1);
    chk1 ("ws_req_after", bus.imem_req_o, 1'b0);
    chk  ("ws_delivered", last_pop_addr, 32'h10);
    gnt_manual = 1'b0;

    // Backpressure: decode stalled, credits run out
    bus.inst_ready_i = 1'b0;
    fetch(32'h20); fetch(32'h24); fetch(32'h28); fetch(32'h2C);
    bus.pc_i       = 32'h30;
    bus.pc_valid_i = 1'b1;
    idle(6);
    @(negedge clk);
    chk1("bp_pc_ready",  bus.pc_ready_o,   1'b0);
    chk1("bp_valid",     bus.inst_valid_o, 1'b1);
    chk ("bp_head_addr", bus.inst_addr_o,  32'h20);
    chk ("bp_head_data", bus.inst_o,       32'h20 ^ KEY);
    pop0 = pop_cnt;
    @(posedge clk);
    #2;
    bus.pc_valid_i   = 1'b0;
    bus.inst_ready_i = 1'b1;
    fetch(32'h30);
    idle(10);
    chk_i("bp_pops", pop_cnt - pop0, 5);
    chk  ("bp_last", last_pop_addr, 32'h30);

    // Flush with two fetches in flight, then redirect to 0x200
    lat_min = 4;
    lat_max = 4;
    fetch(32'h100); fetch(32'h104);
    bus.flush_i = 1'b1;
    idle(1);
    bus.flush_i = 1'b0;
    pop0 = pop_cnt;
    fetch(32'h200);
    idle(15);
    chk_i("fl_pops",      pop_cnt - pop0, 1);
    chk  ("fl_next_addr", last_pop_addr, 32'h200);
    chk_i("fl_used_idle", int'(dut.used_q), 0);

    // Flush in the same cycle as a grant
    lat_min = 3;
    lat_max = 3;
    fetch(32'h300);
    bus.flush_i = 1'b1;
    @(negedge clk);
    chk1("fsg_grant", bus.imem_req_o && bus.imem_gnt_i, 1'b1);
    @(posedge clk);
    #2;
    bus.flush_i = 1'b0;
    @(negedge clk);
    chk1("fsg_req_after", bus.imem_req_o, 1'b0);
    pop0 = pop_cnt;
    idle(8);
    chk_i("fsg_pops",      pop_cnt - pop0, 0);
    chk_i("fsg_used_idle", int'(dut.used_q), 0);
    lat_min = 1;
    lat_max = 1;
    fetch(32'h304);
    idle(6);
    chk_i("fsg_resume_pops", pop_cnt - pop0, 1);
    chk  ("fsg_resume_addr", last_pop_addr, 32'h304);

    // Randomized traffic: random grants, latency, backpressure, redirects
    gnt_rand = 1'b1;
    lat_min  = 1;
    lat_max  = 4;
    for (int n = 0; n < 400; n++) begin
      @(negedge clk);
      acc = bus.pc_valid_i && bus.pc_ready_o;
      @(posedge clk);
      #2;
      bus.inst_ready_i = ($urandom_range(0, 3) != 0);
      bus.flush_i      = ($urandom_range(0, 24) == 0);
      if (acc || !bus.pc_valid_i || bus.flush_i) begin
        bus.pc_valid_i = ($urandom_range(0, 3) != 0);
        bus.pc_i       = $urandom();
      end
    end
    bus.pc_valid_i   = 1'b0;
    bus.flush_i      = 1'b0;
    bus.inst_ready_i = 1'b1;
    gnt_rand         = 1'b0;
    idle(20);
    chk_i("rand_used_idle", int'(dut.used_q), 0);
    chk1 ("rand_valid_idle", bus.inst_valid_o, 1'b0);

    // Reset with three fetches outstanding
    lat_min = 6;
    lat_max = 6;
    fetch(32'h400); fetch(32'h404); fetch(32'h408);
    rst = 1'b1;
    #1;
    chk1("mrst_pc_ready",   bus.pc_ready_o,   1'b0);
    chk1("mrst_imem_req",   bus.imem_req_o,   1'b0);
    chk ("mrst_imem_addr",  bus.imem_addr_o,  32'h0);
    chk1("mrst_inst_valid", bus.inst_valid_o, 1'b0);
    chk ("mrst_inst",       bus.inst_o,       32'h0);
    chk ("mrst_inst_addr",  bus.inst_addr_o,  32'h0);
    @(posedge clk);
    @(posedge clk);
    #2;
    rst     = 1'b0;
    lat_min = 1;
    lat_max = 1;
    pop0    = pop_cnt;
    last_pop_addr = 32'hFFFF_FFFF;
    fetch(32'h0);
    idle(8);
    chk_i("mrst_pops",      pop_cnt - pop0, 1);
    chk  ("mrst_addr",      last_pop_addr, 32'h0);
    chk_i("mrst_used_idle", int'(dut.used_q), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
